// File: rtl/uart_trace_fifo.sv
// Trace capture FIFO that formats each captured word as an uppercase hex line
// and sends it over an 8N1 UART. Drops caused by a full FIFO are flagged with a '!' prefix.
module uart_trace_fifo #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 16,
    parameter int CLK_FREQ = 25000000,
    parameter int BAUD     = 500000,
    parameter int MODE     = 0,
    parameter int GAP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      trace_data,
    input  logic                   trace_valid,
    output logic                   uart_tx,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int AW       = $clog2(DEPTH);
    localparam int LW       = AW + 1;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int GAP_CYC  = GAP_BITS * DIV;
    localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam int CNT_W    = $clog2(DIV + GAP_CYC + 1);
    localparam int NIB      = DATA_W / 4;
    localparam int NW       = $clog2(NIB + 1);

    typedef enum logic [2:0] {F_IDLE, F_DROP, F_HEX, F_CR, F_LF} fmt_t;
    typedef enum logic [1:0] {S_IDLE, S_BITS, S_GAP} ser_t;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] last_captured;
    logic              first_sample;
    logic              capture, full, push, pop, drop;

    fmt_t              fmt_state, fmt_next;
    logic [DATA_W-1:0] word_sr;
    logic [NW-1:0]     nib_cnt;
    logic              drop_pending;
    logic              load;
    logic [7:0]        tx_char;

    ser_t              ser_state, ser_next;
    logic [CNT_W-1:0]  div_cnt;
    logic [3:0]        bit_cnt;
    logic [8:0]        shifter;
    logic              bit_end, last_bit, gap_end, ser_ready;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign full    = (fifo_level == LW'(DEPTH));
    assign capture = trace_valid && (MODE == 0 || first_sample || trace_data != last_captured);
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= trace_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_level    <= '0;
            overflow      <= 1'b0;
            first_sample  <= 1'b1;
            last_captured <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + 1'b1;
                last_captured <= trace_data;
                first_sample  <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) fifo_level <= fifo_level + 1'b1;
            else if (pop && !push) fifo_level <= fifo_level - 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) fmt_state <= F_IDLE;
        else       fmt_state <= fmt_next;
    end

    always_comb begin
        fmt_next = fmt_state;
        pop      = 1'b0;
        load     = 1'b0;
        tx_char  = '0;
        unique case (fmt_state)
            F_IDLE: if (fifo_level != '0) begin
                pop      = 1'b1;
                fmt_next = drop_pending ? F_DROP : F_HEX;
            end
            F_DROP: if (ser_ready) begin
                load     = 1'b1;
                tx_char  = 8'h21;
                fmt_next = F_HEX;
            end
            F_HEX: if (ser_ready) begin
                load    = 1'b1;
                tx_char = hex_char(word_sr[DATA_W-1 -: 4]);
                if (nib_cnt == NW'(NIB - 1)) fmt_next = F_CR;
            end
            F_CR: if (ser_ready) begin
                load     = 1'b1;
                tx_char  = 8'h0D;
                fmt_next = F_LF;
            end
            F_LF: if (ser_ready) begin
                load     = 1'b1;
                tx_char  = 8'h0A;
                fmt_next = F_IDLE;
            end
            default: fmt_next = F_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_sr      <= '0;
            nib_cnt      <= '0;
            drop_pending <= 1'b0;
        end else begin
            if (pop) begin
                word_sr <= mem[rd_ptr];
                nib_cnt <= '0;
            end else if (fmt_state == F_HEX && load) begin
                word_sr <= word_sr << 4;
                nib_cnt <= nib_cnt + 1'b1;
            end
            if (drop) drop_pending <= 1'b1;
            else if (fmt_state == F_DROP && load) drop_pending <= 1'b0;
        end
    end

    assign bit_end  = (div_cnt == CNT_W'(DIV - 1));
    assign last_bit = bit_end && (bit_cnt == 4'd9);
    assign gap_end  = (div_cnt == CNT_W'(GAP_LAST));
    // Ready already in the final high cycle, so the next start bit abuts stop/gap.
    assign ser_ready = (ser_state == S_IDLE)
                    || (ser_state == S_BITS && last_bit && GAP_CYC == 0)
                    || (ser_state == S_GAP && gap_end);

    always_ff @(posedge clk) begin
        if (reset) ser_state <= S_IDLE;
        else       ser_state <= ser_next;
    end

    always_comb begin
        ser_next = ser_state;
        unique case (ser_state)
            S_IDLE: if (load) ser_next = S_BITS;
            S_BITS: if (last_bit) ser_next = load ? S_BITS : ((GAP_CYC == 0) ? S_IDLE : S_GAP);
            S_GAP:  if (gap_end) ser_next = load ? S_BITS : S_IDLE;
            default: ser_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uart_tx <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shifter <= '1;
        end else if (load) begin
            shifter <= {1'b1, tx_char};
            uart_tx <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (ser_state == S_BITS) begin
            if (bit_end) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
                uart_tx <= shifter[0];
                shifter <= {1'b1, shifter[8:1]};
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end else if (ser_state == S_GAP) begin
            div_cnt <= gap_end ? '0 : div_cnt + 1'b1;
            uart_tx <= 1'b1;
        end else begin
            uart_tx <= 1'b1;
        end
    end

endmodule
